// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared combinational ALU.
// Grants one request at a time, issues it for one cycle, then holds the result until the owner accepts it.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [1:0]        r_resp_valid;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_resp_data;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_sel;

    // On a tie, the requester that did not win last time goes next.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign req_ready = ((r_state == S_IDLE) && !reset) ? w_grant : 2'b00;
    assign w_accept  = |(req_valid & req_ready);
    assign w_sel     = req_ready[1];

    // The ALU operand registers double as the ALU drive, so they are zeroed outside ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_resp_valid <= 2'b00;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_ISSUE;
                        r_owner      <= w_sel;
                        r_last_grant <= w_sel;
                        r_alu_op     <= w_sel ? req_op1 : req_op0;
                        r_alu_a      <= w_sel ? req_a1 : req_a0;
                        r_alu_b      <= w_sel ? req_b1 : req_b0;
                    end
                end
                S_ISSUE: begin
                    r_state      <= S_RESP;
                    r_resp_data  <= alu_result;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_alu_op     <= '0;
                    r_alu_a      <= '0;
                    r_alu_b      <= '0;
                end
                S_RESP: begin
                    if (resp_ready[r_owner]) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 2'b00;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus directed literal expectations.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [OW-1:0] req_op0, req_op1;
    logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready;
    logic [DW-1:0] resp_data;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    // transaction model state
    bit            m_active = 1'b0;
    int            m_age    = 0;
    bit            m_owner  = 1'b0;
    bit            m_last   = 1'b1;
    logic [OW-1:0] m_op     = '0;
    logic [DW-1:0] m_a      = '0;
    logic [DW-1:0] m_b      = '0;
    logic [DW-1:0] m_result = '0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd3:    return a + b;
            4'd4:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single requester wins outright; a tie goes to whoever did not win last.
    function automatic logic [1:0] model_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    task automatic compare_model();
        logic [1:0]    e_ready;
        logic [1:0]    e_rv;
        logic [OW-1:0] e_op;
        logic [DW-1:0] e_a;
        logic [DW-1:0] e_b;
        logic          e_busy;
        e_ready = 2'b00; e_rv = 2'b00; e_op = '0; e_a = '0; e_b = '0; e_busy = 1'b0;
        if (!reset) begin
            if (!m_active) begin
                e_ready = model_grant(req_valid, m_last);
            end else if (m_age == 1) begin
                e_op = m_op; e_a = m_a; e_b = m_b; e_busy = 1'b1;
            end else begin
                e_rv = m_owner ? 2'b10 : 2'b01; e_busy = 1'b1;
            end
        end
        check("m_req_ready",  64'(req_ready),  64'(e_ready));
        check("m_busy",       64'(busy),       64'(e_busy));
        check("m_alu_op",     64'(alu_op),     64'(e_op));
        check("m_alu_a",      64'(alu_a),      64'(e_a));
        check("m_alu_b",      64'(alu_b),      64'(e_b));
        check("m_resp_valid", 64'(resp_valid), 64'(e_rv));
        if (reset)
            check("m_resp_data_rst", 64'(resp_data), 64'd0);
        else if (m_active && m_age == 2)
            check("m_resp_data", 64'(resp_data), 64'(m_result));
    endtask

    task automatic update_model();
        logic [1:0] g;
        if (reset) begin
            m_active = 1'b0; m_age = 0; m_owner = 1'b0; m_last = 1'b1;
        end else if (!m_active) begin
            g = model_grant(req_valid, m_last);
            if (g != 2'b00) begin
                m_owner  = g[1];
                m_last   = g[1];
                m_op     = g[1] ? req_op1 : req_op0;
                m_a      = g[1] ? req_a1  : req_a0;
                m_b      = g[1] ? req_b1  : req_b0;
                m_active = 1'b1;
                m_age    = 1;
                $display("txn: owner %0d op %0h a %0h b %0h", m_owner, m_op, m_a, m_b);
            end
        end else if (m_age == 1) begin
            m_result = alu_fn(m_op, m_a, m_b);
            m_age    = 2;
        end else if (resp_ready[m_owner]) begin
            m_active = 1'b0;
            m_age    = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        #2;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

        // reset holds off grants even with both requesting
        sample();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        advance();
        reset = 1'b0; req_valid = 2'b00;
        step();

        // single add request, then operand change during ISSUE
        req_valid = 2'b01; req_op0 = 4'd3; req_a0 = 32'd5; req_b0 = 32'd7;
        sample();
        check("single_ready", 64'(req_ready), 64'h1);
        advance();
        req_a0 = 32'd99; req_valid = 2'b00;
        sample();
        check("issue_op", 64'(alu_op), 64'h3);
        check("issue_a",  64'(alu_a),  64'd5);
        check("issue_b",  64'(alu_b),  64'd7);
        advance();

        // backpressure for 5 cycles while requester 1 waits
        resp_ready = 2'b00; req_valid = 2'b10; req_op1 = 4'd4; req_a1 = 32'd100; req_b1 = 32'd30;
        repeat (5) begin
            sample();
            check("bp_resp_valid", 64'(resp_valid), 64'h1);
            check("bp_resp_data",  64'(resp_data),  64'd12);
            check("bp_busy",       64'(busy),       64'd1);
            check("bp_req_ready",  64'(req_ready),  64'd0);
            advance();
        end
        resp_ready = 2'b01;
        step();
        resp_ready = 2'b00;
        sample();
        check("after_hs_busy",  64'(busy),      64'd0);
        check("after_hs_ready", 64'(req_ready), 64'h2);
        advance();
        req_valid = 2'b00;
        step();

        // owner 1 ignores resp_ready bit 0
        resp_ready = 2'b01;
        repeat (3) begin
            sample();
            check("wrongbit_resp_valid", 64'(resp_valid), 64'h2);
            check("wrongbit_resp_data",  64'(resp_data),  64'd70);
            advance();
        end
        resp_ready = 2'b10;
        step();
        sample();
        check("owner1_done_busy", 64'(busy), 64'd0);
        advance();

        // tie arbitration after reset alternates 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0; req_valid = 2'b11; resp_ready = 2'b11;
        req_op0 = 4'd0; req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_FF00;
        req_op1 = 4'd1; req_a1 = 32'h0000_000F; req_b1 = 32'h0000_00F0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("tie_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            advance();
            step();
            sample();
            check("tie_data", 64'(resp_data), (i % 2 == 0) ? 64'h0000_F000 : 64'h0000_00FF);
            advance();
        end

        // full-width wraparound add
        req_valid = 2'b01; req_op0 = 4'd3; req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd2;
        sample();
        check("wrap_ready", 64'(req_ready), 64'h1);
        advance();
        req_valid = 2'b00;
        step();
        sample();
        check("wrap_data", 64'(resp_data), 64'd1);
        advance();

        // reset pulsed during ISSUE aborts the transaction
        req_valid = 2'b01; req_op0 = 4'd3; req_a0 = 32'd1; req_b0 = 32'd2; resp_ready = 2'b01;
        step();
        reset = 1'b1; req_valid = 2'b00;
        sample();
        check("midrst_alu_op",     64'(alu_op),     64'd0);
        check("midrst_alu_a",      64'(alu_a),      64'd0);
        check("midrst_busy",       64'(busy),       64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        advance();
        reset = 1'b0;
        repeat (3) begin
            sample();
            check("midrst_no_resp", 64'(resp_valid), 64'd0);
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
